// File: rtl/ca_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ca_pkg                                                          |
// | Purpose  : Shared widths, sequencer state encoding and the substitute      |
// |            pixel used by the chromatic-adaptation frame sequencer.         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ca_pkg;

  localparam int RGB_W    = 24;
  localparam int COEF_W   = 32;
  localparam int MATRIX_W = 288;

  // Substituted for a pixel the processor never returned.
  localparam logic [RGB_W-1:0] ERR_RGB = 24'hFF0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

endpackage : ca_pkg
`default_nettype wire

// File: rtl/ca_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ca_sync_fifo                                                    |
// | Purpose  : Single-clock first-word-fall-through FIFO carrying {last,rgb}.  |
// | Ports    : clk, rst_n      clock / async active-low reset                 |
// |            i_push, i_data  write strobe and word                           |
// |            i_pop           read strobe (ignored when empty)                |
// |            o_data          head word, valid whenever o_empty is low        |
// |            o_empty         no words stored                                 |
// |            o_count         number of words stored                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ca_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4,
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int c_CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [c_CW-1:0]  o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  logic w_do_pop;
  logic w_do_push;

  // A push into a full FIFO is allowed when the same cycle frees a slot.
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != c_CW'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule : ca_sync_fifo
`default_nettype wire

// File: rtl/ca_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ca_frame_sequencer                                              |
// | Purpose  : Sequences the chromatic-adaptation image processor over whole   |
// |            frames: credit-limited pixel streaming, double-buffered 3x3     |
// |            matrix applied at frame boundaries, output FIFO to the sink,    |
// |            frame completion and sticky error reporting.                    |
// | Ports    : clk, rst_n                  clock / async active-low reset     |
// |            cfg_matrix[_wr], cfg_pending shadow matrix write / status      |
// |            frame_start, busy, frame_done, frame_cnt   frame control       |
// |            src_rgb/valid/ready          pixel source                      |
// |            proc_rgb/valid/ready, proc_matrix[_valid]  processor input     |
// |            proc_out_rgb/valid           processor output (no backpressure)|
// |            dst_rgb/valid/last/ready     sink                              |
// |            err_spurious, err_timeout    sticky error flags                |
// | Config   : define CA_SEQ_TIMEOUT_EN to build the lost-pixel watchdog.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ca_frame_sequencer
  import ca_pkg::*;
#(
  parameter int IMG_W          = 6,
  parameter int IMG_H          = 4,
  parameter int MAX_INFLIGHT   = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MATRIX_W-1:0] cfg_matrix,
  input  logic                cfg_matrix_wr,
  output logic                cfg_pending,
  input  logic                frame_start,
  input  logic [RGB_W-1:0]    src_rgb,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [RGB_W-1:0]    proc_rgb,
  output logic                proc_valid,
  input  logic                proc_ready,
  output logic [MATRIX_W-1:0] proc_matrix,
  output logic                proc_matrix_valid,
  input  logic [RGB_W-1:0]    proc_out_rgb,
  input  logic                proc_out_valid,
  output logic [RGB_W-1:0]    dst_rgb,
  output logic                dst_valid,
  output logic                dst_last,
  input  logic                dst_ready,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  output logic                err_spurious,
  output logic                err_timeout
);

  localparam int c_NPIX = IMG_W * IMG_H;
  localparam int c_XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_PW   = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;
  localparam int c_IFW  = $clog2(MAX_INFLIGHT + 1);
  localparam int c_FCW  = $clog2(FIFO_DEPTH + 1);

  // The credit rule only prevents FIFO overflow if the FIFO can hold every
  // pixel that may be in flight.
  if (FIFO_DEPTH < MAX_INFLIGHT || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ca_frame_sequencer: FIFO_DEPTH must be >= MAX_INFLIGHT and TIMEOUT_CYCLES >= 1");
  end

  seq_state_t          r_state;
  logic [MATRIX_W-1:0] r_shadow;
  logic [MATRIX_W-1:0] r_active;
  logic                r_pending;
  logic                r_mvalid;
  logic                r_frame_done;
  logic [15:0]         r_frame_cnt;
  logic                r_err_spur;
  logic [c_XW-1:0]     r_x;
  logic [c_YW-1:0]     r_y;
  logic [c_IFW-1:0]    r_inflight;
  logic [c_PW-1:0]     r_out_idx;

  logic                w_in_stream;
  logic                w_credit_ok;
  logic                w_accept;
  logic                w_last_pix;
  logic                w_ret;
  logic                w_wd_fire;
  logic                w_dec;
  logic                w_push;
  logic [RGB_W-1:0]    w_push_rgb;
  logic                w_push_last;
  logic                w_pop;
  logic [RGB_W:0]      w_fifo_data;
  logic                w_fifo_empty;
  logic [c_FCW-1:0]    w_fifo_count;

  // --------------------------------------------------------------------------
  // Input handshake
  // --------------------------------------------------------------------------
  assign w_in_stream = (r_state == S_STREAM);

  // Counting FIFO occupancy together with in-flight pixels reserves a FIFO
  // slot for every pixel before it is handed to the processor.
  assign w_credit_ok = (32'(r_inflight) < 32'(MAX_INFLIGHT)) &&
                       ((32'(r_inflight) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH));

  assign src_ready  = w_in_stream & proc_ready & w_credit_ok;
  assign proc_valid = w_in_stream & src_valid & w_credit_ok;
  assign proc_rgb   = w_in_stream ? src_rgb : '0;
  assign w_accept   = src_valid & src_ready;
  assign w_last_pix = (r_x == c_XW'(IMG_W - 1)) && (r_y == c_YW'(IMG_H - 1));

  // --------------------------------------------------------------------------
  // Return path: only returns matched to an in-flight pixel are counted.
  // --------------------------------------------------------------------------
  assign w_ret       = proc_out_valid & (r_inflight != '0);
  assign w_dec       = w_ret | w_wd_fire;
  assign w_push      = w_dec;
  assign w_push_rgb  = w_wd_fire ? ERR_RGB : proc_out_rgb;
  assign w_push_last = (r_out_idx == c_PW'(c_NPIX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_out_idx  <= '0;
      r_err_spur <= 1'b0;
    end else begin
      case ({w_accept, w_dec})
        2'b10:   r_inflight <= r_inflight + c_IFW'(1);
        2'b01:   r_inflight <= r_inflight - c_IFW'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_push) begin
        r_out_idx <= w_push_last ? '0 : r_out_idx + c_PW'(1);
      end
      if (proc_out_valid && (r_inflight == '0)) begin
        r_err_spur <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lost-pixel watchdog
  // --------------------------------------------------------------------------
`ifdef CA_SEQ_TIMEOUT_EN
  localparam int c_WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_WDW-1:0] r_wd;
  logic             r_err_to;

  // A real return in the same cycle wins over the watchdog, so the two
  // decrement sources are mutually exclusive.
  assign w_wd_fire = (r_inflight != '0) && !proc_out_valid &&
                     (r_wd == c_WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd     <= '0;
      r_err_to <= 1'b0;
    end else begin
      if ((r_inflight == '0) || proc_out_valid || w_wd_fire) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + c_WDW'(1);
      end
      if (w_wd_fire) begin
        r_err_to <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err_to;
`else
  assign w_wd_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  assign w_pop = dst_ready & ~w_fifo_empty;

  ca_sync_fifo #(
    .WIDTH (RGB_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({w_push_last, w_push_rgb}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Stale storage is masked so an empty FIFO presents all-zero outputs.
  assign dst_valid = ~w_fifo_empty;
  assign dst_rgb   = dst_valid ? w_fifo_data[RGB_W-1:0] : '0;
  assign dst_last  = dst_valid & w_fifo_data[RGB_W];

  // --------------------------------------------------------------------------
  // Frame FSM, pixel position and matrix double buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_mvalid     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start && r_pending) begin
            r_state <= S_LOAD;
            r_x     <= '0;
            r_y     <= '0;
          end else if (frame_start && r_mvalid) begin
            r_state <= S_STREAM;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        S_LOAD: begin
          r_active  <= r_shadow;
          r_mvalid  <= 1'b1;
          r_pending <= 1'b0;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_state <= S_DRAIN;
              r_x     <= '0;
              r_y     <= '0;
            end else if (r_x == c_XW'(IMG_W - 1)) begin
              r_x <= '0;
              r_y <= r_y + c_YW'(1);
            end else begin
              r_x <= r_x + c_XW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_inflight == '0) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Placed after the LOAD copy so a write in the LOAD cycle keeps the
      // new value pending for the following frame.
      if (cfg_matrix_wr) begin
        r_shadow  <= cfg_matrix;
        r_pending <= 1'b1;
      end
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign frame_done        = r_frame_done;
  assign frame_cnt         = r_frame_cnt;
  assign cfg_pending       = r_pending;
  assign proc_matrix       = r_active;
  assign proc_matrix_valid = r_mvalid;
  assign err_spurious      = r_err_spur;

endmodule : ca_frame_sequencer
`default_nettype wire

// File: tb/tb_ca_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ca_frame_sequencer                                           |
// | Purpose  : Self-checking bench for ca_frame_sequencer with an in-bench     |
// |            fixed-latency processor model and an output scoreboard.         |
// | Ports    : none                                                            |
// | Config   : CA_SEQ_TIMEOUT_EN enables the dropped-pixel scenario.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ca_frame_sequencer;
  import ca_pkg::*;

  localparam int NPIX = 24;
  localparam int LAT  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [287:0]  cfg_matrix;
  logic          cfg_matrix_wr;
  logic          cfg_pending;
  logic          frame_start;
  logic [23:0]   src_rgb;
  logic          src_valid;
  logic          src_ready;
  logic [23:0]   proc_rgb;
  logic          proc_valid;
  logic          proc_ready;
  logic [287:0]  proc_matrix;
  logic          proc_matrix_valid;
  logic [23:0]   proc_out_rgb;
  logic          proc_out_valid;
  logic [23:0]   dst_rgb;
  logic          dst_valid;
  logic          dst_last;
  logic          dst_ready;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          err_spurious;
  logic          err_timeout;

  ca_frame_sequencer #(
    .IMG_W(6), .IMG_H(4), .MAX_INFLIGHT(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_matrix(cfg_matrix), .cfg_matrix_wr(cfg_matrix_wr), .cfg_pending(cfg_pending),
    .frame_start(frame_start),
    .src_rgb(src_rgb), .src_valid(src_valid), .src_ready(src_ready),
    .proc_rgb(proc_rgb), .proc_valid(proc_valid), .proc_ready(proc_ready),
    .proc_matrix(proc_matrix), .proc_matrix_valid(proc_matrix_valid),
    .proc_out_rgb(proc_out_rgb), .proc_out_valid(proc_out_valid),
    .dst_rgb(dst_rgb), .dst_valid(dst_valid), .dst_last(dst_last), .dst_ready(dst_ready),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] rgb; int due; } pm_t;
  typedef struct {
    int          mode;     // 0: sink always ready, 2: random sink/processor ready
    int          hold;     // cycles the sink is stalled at frame start
    bit          wr;       // write a new matrix before the frame
    logic [31:0] d0;       // element 0 of the written matrix
    int          exp_cnt;  // frame_cnt after the frame
    logic [31:0] exp_m0;   // active element 0 after the frame
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [23:0] sb[$];
  pm_t         pq[$];
  int          out_pos = 0, beats = 0, lasts = 0, dones = 0;
  int          src_idx = 0, src_left = 0, frame_tag = 0, drop_idx = -1;
  bit          drop_pend = 1'b0, dst_hold = 1'b0;
  int          rdy_mode = 0;
  vec_t        vecs[4];

  function automatic logic [23:0] pat(input int tag, input int i);
    return {8'(tag * 37 + i), 8'(i * 11 + 3), 8'(255 - i)};
  endfunction

  // Stand-in for the colour transform of the real processor.
  function automatic logic [23:0] proc_f(input logic [23:0] p);
    return p ^ 24'h3C5AA5;
  endfunction

  function automatic logic [287:0] diag(input logic [31:0] a);
    logic [287:0] m;
    m = '0;
    m[31:0]    = a;
    m[159:128] = 32'h00010CCC;
    m[287:256] = 32'h0000E666;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // One clock: observe the handshakes at the negedge, then drive the next
  // cycle's inputs just after the posedge.
  task automatic tick();
    logic [23:0] e;
    @(negedge clk);
    if (src_valid && src_ready) begin
      if (src_idx == drop_idx) drop_pend = 1'b1;
      else begin
        sb.push_back(proc_f(src_rgb));
        pq.push_back('{proc_f(src_rgb), cyc + LAT});
      end
      // A lost pixel is replaced only after every other return has drained.
      if (src_idx == NPIX - 1 && drop_pend) begin
        sb.push_back(ERR_RGB);
        drop_pend = 1'b0;
      end
      src_idx++;
      src_left--;
    end
    if (dst_valid && dst_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dst_extra: got beat 'h%0h, expected no beat", dst_rgb);
      end else begin
        e = sb.pop_front();
        check("dst_rgb", 64'(dst_rgb), 64'(e));
        check("dst_last", 64'(dst_last), 64'(out_pos == NPIX - 1));
      end
      out_pos = (out_pos == NPIX - 1) ? 0 : out_pos + 1;
      beats++;
      if (dst_last) lasts++;
    end
    if (frame_done) dones++;
    @(posedge clk);
    #1;
    cyc++;
    frame_start   = 1'b0;
    cfg_matrix_wr = 1'b0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      proc_out_valid = 1'b1;
      proc_out_rgb   = pq[0].rgb;
      void'(pq.pop_front());
    end else begin
      proc_out_valid = 1'b0;
      proc_out_rgb   = '0;
    end
    src_valid  = (src_left > 0);
    src_rgb    = pat(frame_tag, src_idx);
    proc_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    dst_ready  = !dst_hold && (rdy_mode == 0 || $urandom_range(0, 1) == 1);
  endtask

  task automatic write_matrix(input logic [287:0] m);
    cfg_matrix    = m;
    cfg_matrix_wr = 1'b1;
    tick();
  endtask

  task automatic start_frame();
    src_idx     = 0;
    src_left    = NPIX;
    frame_tag++;
    beats       = 0;
    lasts       = 0;
    dones       = 0;
    frame_start = 1'b1;
    tick();
  endtask

  task automatic finish_frame(input int budget);
    int n;
    n = 0;
    while ((dones == 0 || sb.size() != 0 || dst_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_wait: got no completion after %0d cycles, expected frame_done and drained output", budget);
    end
  endtask

  task automatic frame_checks(input int exp_cnt);
    check("beats", 64'(beats), 64'(NPIX));
    check("last_count", 64'(lasts), 64'd1);
    check("done_pulses", 64'(dones), 64'd1);
    check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_src_ready"}, 64'(src_ready), 64'd0);
    check({tag, "_proc_valid"}, 64'(proc_valid), 64'd0);
    check({tag, "_proc_rgb"}, 64'(proc_rgb), 64'd0);
    check({tag, "_dst_valid"}, 64'(dst_valid), 64'd0);
    check({tag, "_dst_rgb"}, 64'(dst_rgb), 64'd0);
    check({tag, "_dst_last"}, 64'(dst_last), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    check({tag, "_cfg_pending"}, 64'(cfg_pending), 64'd0);
    check({tag, "_mvalid"}, 64'(proc_matrix_valid), 64'd0);
    check({tag, "_matrix"}, 64'(|proc_matrix), 64'd0);
    check({tag, "_err_spurious"}, 64'(err_spurious), 64'd0);
    check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
  endtask

  initial begin
    vecs[0] = '{0, 0,  1'b1, 32'h00011999, 1, 32'h00011999};
    vecs[1] = '{0, 30, 1'b0, 32'h0,        2, 32'h00011999};
    vecs[2] = '{2, 0,  1'b1, 32'h00020000, 3, 32'h00020000};
    vecs[3] = '{2, 0,  1'b0, 32'h0,        4, 32'h00020000};

    rst_n = 1'b0; cfg_matrix = '0; cfg_matrix_wr = 1'b0; frame_start = 1'b0;
    src_rgb = '0; src_valid = 1'b0; proc_ready = 1'b1; proc_out_rgb = '0;
    proc_out_valid = 1'b0; dst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_check("rst");
    rst_n = 1'b1;
    tick();
    tick();

    // frame_start with no matrix ever loaded is ignored
    src_left    = NPIX;
    frame_start = 1'b1;
    repeat (3) tick();
    check("nomat_busy", 64'(busy), 64'd0);
    check("nomat_src_ready", 64'(src_ready), 64'd0);
    check("nomat_proc_valid", 64'(proc_valid), 64'd0);
    src_left = 0;
    tick();

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].wr) write_matrix(diag(vecs[i].d0));
      rdy_mode = vecs[i].mode;
      dst_hold = (vecs[i].hold > 0);
      start_frame();
      for (int h = 0; h < vecs[i].hold; h++) tick();
      if (vecs[i].hold > 0) begin
        check("hold_accepted", 64'(src_idx), 64'd4);
        check("hold_src_ready", 64'(src_ready), 64'd0);
        check("hold_dst_valid", 64'(dst_valid), 64'd1);
      end
      dst_hold = 1'b0;
      finish_frame(2000);
      frame_checks(vecs[i].exp_cnt);
      check("tbl_pending", 64'(cfg_pending), 64'd0);
      check("tbl_m0", 64'(proc_matrix[31:0]), 64'(vecs[i].exp_m0));
      check("tbl_m1", 64'(proc_matrix[63:32]), 64'd0);
      check("tbl_m4", 64'(proc_matrix[159:128]), 64'h00010CCC);
      check("tbl_m8", 64'(proc_matrix[287:256]), 64'h0000E666);
    end

    // matrix write mid-STREAM is held back until the next frame boundary
    rdy_mode = 0;
    start_frame();
    repeat (6) tick();
    write_matrix(diag(32'h00030000));
    check("mid_pending", 64'(cfg_pending), 64'd1);
    check("mid_m0", 64'(proc_matrix[31:0]), 64'h00020000);
    finish_frame(2000);
    frame_checks(5);
    check("mid_end_m0", 64'(proc_matrix[31:0]), 64'h00020000);
    check("mid_end_pending", 64'(cfg_pending), 64'd1);

    // write in the LOAD cycle: old shadow applied, new one stays pending
    start_frame();
    check("load_busy", 64'(busy), 64'd1);
    check("load_m0_before", 64'(proc_matrix[31:0]), 64'h00020000);
    cfg_matrix    = diag(32'h00040000);
    cfg_matrix_wr = 1'b1;
    tick();
    check("load_m0_after", 64'(proc_matrix[31:0]), 64'h00030000);
    check("load_pending", 64'(cfg_pending), 64'd1);
    finish_frame(2000);
    frame_checks(6);
    start_frame();
    tick();
    check("reload_m0", 64'(proc_matrix[31:0]), 64'h00040000);
    check("reload_pending", 64'(cfg_pending), 64'd0);
    finish_frame(2000);
    frame_checks(7);

    // return with nothing in flight is discarded and flagged
    proc_out_valid = 1'b1;
    proc_out_rgb   = 24'h123456;
    @(posedge clk);
    #1;
    proc_out_valid = 1'b0;
    check("spur_flag", 64'(err_spurious), 64'd1);
    check("spur_dst_valid", 64'(dst_valid), 64'd0);
    tick();
    check("spur_still_empty", 64'(dst_valid), 64'd0);

`ifdef CA_SEQ_TIMEOUT_EN
    drop_idx = 5;
    start_frame();
    finish_frame(3000);
    drop_idx = -1;
    frame_checks(8);
    check("timeout_flag", 64'(err_timeout), 64'd1);
`else
    check("timeout_tied", 64'(err_timeout), 64'd0);
`endif

    // asynchronous reset mid-STREAM with pixels in flight
    start_frame();
    repeat (5) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check("arst");
    sb.delete();
    pq.delete();
    src_left = 0; src_idx = 0; out_pos = 0; drop_pend = 1'b0;
    proc_out_valid = 1'b0; src_valid = 1'b0;
    repeat (3) tick();
    check("arst_no_recovery", 64'(dst_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    write_matrix(diag(32'h00011999));
    start_frame();
    finish_frame(2000);
    frame_checks(1);
    check("post_rst_m0", 64'(proc_matrix[31:0]), 64'h00011999);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected $finish before 50000 cycles");
    $fatal(1, "bench time limit");
  end

endmodule : tb_ca_frame_sequencer
`default_nettype wire
